// File: rtl/tmds_period_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : tmds_period_scheduler_if
//  Description : Bundle between the raster/TMDS period scheduler and its
//                consumers (TMDS encoders, pattern renderer).
//                  pix_en        - pixel strobe into the scheduler
//                  x_out/y_out   - current pixel column/line (12 bit)
//                  frame_start   - one-cycle pulse at (0,0)
//                  ctrl_or_video - 1 = video period, 0 = control
//                  ctl_ch0..2    - control_data_in for channels 0..2
//                  guard_band    - substitute video guard-band codes
//  Revision    : 1.0  initial release
// ============================================================================
interface tmds_period_scheduler_if;
    logic        pix_en;
    logic [11:0] x_out;
    logic [11:0] y_out;
    logic        frame_start;
    logic        ctrl_or_video;
    logic [1:0]  ctl_ch0;
    logic [1:0]  ctl_ch1;
    logic [1:0]  ctl_ch2;
    logic        guard_band;

    // master = the scheduler itself
    modport master (
        input  pix_en,
        output x_out, y_out, frame_start, ctrl_or_video,
        output ctl_ch0, ctl_ch1, ctl_ch2, guard_band
    );

    // slave = whoever consumes the timing
    modport slave (
        output pix_en,
        input  x_out, y_out, frame_start, ctrl_or_video,
        input  ctl_ch0, ctl_ch1, ctl_ch2, guard_band
    );
endinterface
`default_nettype wire

// File: rtl/tmds_period_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tmds_period_scheduler
//  Description : Raster timing generator and TMDS period scheduler. Counts
//                pixels/lines and classifies each pixel clock as control,
//                preamble, video guard band or video period.
//  Ports       : clk  - pixel clock
//                rst  - synchronous reset, active-high
//                bus  - tmds_period_scheduler_if.master (pix_en in;
//                       x_out, y_out, frame_start, ctrl_or_video,
//                       ctl_ch0/1/2, guard_band out)
//  Config      : HDMI_GUARD_BAND_EN - when defined, emit HDMI data-island-free
//                preamble and video guard band ahead of each active line;
//                when undefined, plain DVI (control <-> video only).
//  Revision    : 1.0  initial release
// ============================================================================
module tmds_period_scheduler #(
    parameter int   H_ACTIVE  = 640,
    parameter int   H_FRONT   = 16,
    parameter int   H_SYNC    = 96,
    parameter int   H_BACK    = 48,
    parameter int   V_ACTIVE  = 480,
    parameter int   V_FRONT   = 10,
    parameter int   V_SYNC    = 2,
    parameter int   V_BACK    = 33,
    parameter logic HSYNC_POL = 1'b0,
    parameter logic VSYNC_POL = 1'b0
) (
    input  wire logic               clk,
    input  wire logic               rst,
    tmds_period_scheduler_if.master bus
);

    localparam int c_h_total = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int c_v_total = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [11:0] c_h_last     = 12'(c_h_total - 1);
    localparam logic [11:0] c_v_last     = 12'(c_v_total - 1);
    localparam logic [11:0] c_h_active   = 12'(H_ACTIVE);
    localparam logic [11:0] c_v_active   = 12'(V_ACTIVE);
    localparam logic [11:0] c_hs_first   = 12'(H_ACTIVE + H_FRONT);
    localparam logic [11:0] c_hs_last    = 12'(H_ACTIVE + H_FRONT + H_SYNC - 1);
    localparam logic [11:0] c_vs_first   = 12'(V_ACTIVE + V_FRONT);
    localparam logic [11:0] c_vs_last    = 12'(V_ACTIVE + V_FRONT + V_SYNC - 1);

    localparam logic [1:0] c_st_control  = 2'd0;
    localparam logic [1:0] c_st_video    = 2'd3;
`ifdef HDMI_GUARD_BAND_EN
    localparam logic [1:0] c_st_preamble = 2'd1;
    localparam logic [1:0] c_st_guard    = 2'd2;
    // Preamble is 8 pixels, guard band the last 2 pixels before active video
    localparam logic [11:0] c_h_pre      = 12'(c_h_total - 10);
    localparam logic [11:0] c_h_grd      = 12'(c_h_total - 2);
    localparam logic [11:0] c_v_act_last = 12'(V_ACTIVE - 1);
`endif

    // ------------------------------------------------------------------
    // Elaboration-time sanity checks
    // ------------------------------------------------------------------
    if (c_h_total > 4095) begin : g_h_total_chk
        $error("tmds_period_scheduler: H_TOTAL exceeds 12-bit counter range");
    end
    if (c_v_total > 4095) begin : g_v_total_chk
        $error("tmds_period_scheduler: V_TOTAL exceeds 12-bit counter range");
    end
`ifdef HDMI_GUARD_BAND_EN
    if (H_BACK < 10) begin : g_h_back_chk
        $error("tmds_period_scheduler: H_BACK must be >= 10 for preamble + guard band");
    end
`endif

    // ------------------------------------------------------------------
    // Position counters. The counters are the x/y outputs themselves; all
    // other outputs are registered from the decode of the *next* position so
    // that every output describes the same pixel in the same cycle.
    // ------------------------------------------------------------------
    logic [11:0] r_h;
    logic [11:0] r_v;
    logic [1:0]  r_state;
    logic        r_frame_start;
    logic        r_video;
    logic [1:0]  r_ctl0;

    logic [11:0] w_h_nxt;
    logic [11:0] w_v_nxt;
    logic [1:0]  w_state_nxt;
    logic        w_hsync;
    logic        w_vsync;
    logic        w_v_active;

    always_comb begin
        w_h_nxt = r_h + 12'd1;
        w_v_nxt = r_v;
        if (r_h == c_h_last) begin
            w_h_nxt = 12'd0;
            w_v_nxt = (r_v == c_v_last) ? 12'd0 : r_v + 12'd1;
        end
    end

    assign w_hsync    = ((w_h_nxt >= c_hs_first) && (w_h_nxt <= c_hs_last)) ? HSYNC_POL : ~HSYNC_POL;
    assign w_vsync    = ((w_v_nxt >= c_vs_first) && (w_v_nxt <= c_vs_last)) ? VSYNC_POL : ~VSYNC_POL;
    assign w_v_active = (w_v_nxt < c_v_active);

`ifdef HDMI_GUARD_BAND_EN
    // A preamble is only due when the line that follows carries video
    logic w_next_line_active;
    assign w_next_line_active = (w_v_nxt == c_v_last) || (w_v_nxt < c_v_act_last);
`endif

    // ------------------------------------------------------------------
    // Period FSM, stepped once per enabled pixel
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
`ifdef HDMI_GUARD_BAND_EN
            c_st_control: begin
                if ((w_h_nxt == c_h_pre) && w_next_line_active)
                    w_state_nxt = c_st_preamble;
            end
            c_st_preamble: begin
                if (w_h_nxt == c_h_grd)
                    w_state_nxt = c_st_guard;
            end
            c_st_guard: begin
                if (w_h_nxt == 12'd0)
                    w_state_nxt = w_v_active ? c_st_video : c_st_control;
            end
`else
            c_st_control: begin
                if ((w_h_nxt == 12'd0) && w_v_active)
                    w_state_nxt = c_st_video;
            end
`endif
            c_st_video: begin
                if (w_h_nxt == c_h_active)
                    w_state_nxt = c_st_control;
            end
            default: w_state_nxt = c_st_control;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_h           <= 12'd0;
            r_v           <= c_v_last;
            r_state       <= c_st_control;
            r_frame_start <= 1'b0;
            r_video       <= 1'b0;
            r_ctl0        <= {~VSYNC_POL, ~HSYNC_POL};
        end else if (bus.pix_en) begin
            r_h           <= w_h_nxt;
            r_v           <= w_v_nxt;
            r_state       <= w_state_nxt;
            r_frame_start <= (w_h_nxt == 12'd0) && (w_v_nxt == 12'd0);
            r_video       <= (w_state_nxt == c_st_video);
            r_ctl0        <= {w_vsync, w_hsync};
        end else begin
            // Held pixel: everything freezes except the start pulse
            r_frame_start <= 1'b0;
        end
    end

`ifdef HDMI_GUARD_BAND_EN
    logic       r_guard;
    logic [1:0] r_ctl1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_guard <= 1'b0;
            r_ctl1  <= 2'b00;
        end else if (bus.pix_en) begin
            r_guard <= (w_state_nxt == c_st_guard);
            // CTL0=1 during the video preamble
            r_ctl1  <= (w_state_nxt == c_st_preamble) ? 2'b01 : 2'b00;
        end
    end

    assign bus.guard_band = r_guard;
    assign bus.ctl_ch1    = r_ctl1;
`else
    assign bus.guard_band = 1'b0;
    assign bus.ctl_ch1    = 2'b00;
`endif

    // CTL3/CTL2 are zero in every period this scheduler produces
    assign bus.ctl_ch2       = 2'b00;
    assign bus.x_out         = r_h;
    assign bus.y_out         = r_v;
    assign bus.frame_start   = r_frame_start;
    assign bus.ctrl_or_video = r_video;
    assign bus.ctl_ch0       = r_ctl0;

endmodule
`default_nettype wire

// File: tb/tb_tmds_period_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tmds_period_scheduler
//  Description : Directed bench. A reduced raster (38 x 13) keeps whole frames
//                short; a default-parameter instance covers the 800-pixel line
//                and the reset values of the standard 640x480 timing.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_tmds_period_scheduler;

    localparam int HA = 16, HF = 4, HS = 6, HB = 12, HT = HA + HF + HS + HB;  // 38
    localparam int VA = 6,  VF = 2, VS = 2, VB = 3,  VT = VA + VF + VS + VB;  // 13

`ifdef HDMI_GUARD_BAND_EN
    localparam logic GB = 1'b1;
`else
    localparam logic GB = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic pix_en;

    always #5 clk = ~clk;

    tmds_period_scheduler_if if_s ();
    tmds_period_scheduler_if if_d ();
    assign if_s.pix_en = pix_en;
    assign if_d.pix_en = pix_en;

    tmds_period_scheduler #(
        .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
    ) dut_s (
        .clk(clk),
        .rst(rst),
        .bus(if_s)
    );

    tmds_period_scheduler dut_d (
        .clk(clk),
        .rst(rst),
        .bus(if_d)
    );

    int total  = 0;
    int passed = 0;
    int fails  = 0;

    // Reference position of the reduced instance
    int   mx, my;
    logic efs;

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] expv);
        total++;
        assert (obs === expv) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic logic next_line_active(input int y);
        return (y == VT - 1) || (y < VA - 1);
    endfunction

    task automatic compare_small();
        logic ev, hs, vs, pre, gd;
        ev  = (mx < HA) && (my < VA);
        hs  = !((mx >= HA + HF) && (mx < HA + HF + HS));
        vs  = !((my >= VA + VF) && (my < VA + VF + VS));
        pre = GB && (mx >= HT - 10) && (mx <= HT - 3) && next_line_active(my);
        gd  = GB && (mx >= HT - 2) && next_line_active(my);
        check("x_out",         if_s.x_out,                 12'(mx));
        check("y_out",         if_s.y_out,                 12'(my));
        check("frame_start",   12'(if_s.frame_start),      12'(efs));
        check("ctrl_or_video", 12'(if_s.ctrl_or_video),    12'(ev));
        check("ctl_ch0",       12'(if_s.ctl_ch0),          12'({vs, hs}));
        check("ctl_ch1",       12'(if_s.ctl_ch1),          pre ? 12'd1 : 12'd0);
        check("ctl_ch2",       12'(if_s.ctl_ch2),          12'd0);
        check("guard_band",    12'(if_s.guard_band),       12'(gd));
    endtask

    // One clock: advance the reference on the edge, compare on the falling edge
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            mx = 0; my = VT - 1; efs = 1'b0;
        end else if (pix_en) begin
            if (mx == HT - 1) begin
                mx = 0;
                my = (my == VT - 1) ? 0 : my + 1;
            end else begin
                mx = mx + 1;
            end
            efs = (mx == 0) && (my == 0);
        end else begin
            efs = 1'b0;
        end
        @(negedge clk);
        compare_small();
    endtask

    initial begin
        int dfs, fs1, fs2, vcnt;
        logic found;
        dfs = 0; fs1 = -1; fs2 = -1; vcnt = 0; found = 1'b0;
        mx = 0; my = VT - 1; efs = 1'b0;

        // ---------------- reset, with pix_en high (rst wins) ----------------
        rst = 1'b1; pix_en = 1'b1;
        repeat (3) tick();
        check("d_rst_x",     if_d.x_out,                 12'd0);
        check("d_rst_y",     if_d.y_out,                 12'd524);
        check("d_rst_fs",    12'(if_d.frame_start),      12'd0);
        check("d_rst_cov",   12'(if_d.ctrl_or_video),    12'd0);
        check("d_rst_gb",    12'(if_d.guard_band),       12'd0);
        check("d_rst_ctl0",  12'(if_d.ctl_ch0),          12'd3);
        check("d_rst_ctl1",  12'(if_d.ctl_ch1),          12'd0);
        check("d_rst_ctl2",  12'(if_d.ctl_ch2),          12'd0);

        // ---------------- free run, pix_en always 1 ----------------
        rst = 1'b0;
        for (int i = 1; i <= 1000; i++) begin
            tick();
            if (i <= 800 && if_d.frame_start) dfs++;
            if (if_s.frame_start) begin
                if (fs1 < 0) fs1 = i; else if (fs2 < 0) fs2 = i;
            end
            if (i >= 38 && i <= 531 && if_s.ctrl_or_video) vcnt++;
            // hand-computed points: tick i shows pixel index i from (0,12)
            if (i == 28)  check("pre_x28_y12",   12'(if_s.ctl_ch1),       GB ? 12'd1 : 12'd0);
            if (i == 36)  check("gb_x36_y12",    12'(if_s.guard_band),    12'(GB));
            if (i == 38)  check("vid_x0_y0",     12'(if_s.ctrl_or_video), 12'd1);
            if (i == 53)  check("vid_x15",       12'(if_s.ctrl_or_video), 12'd1);
            if (i == 54)  check("vid_x16",       12'(if_s.ctrl_or_video), 12'd0);
            if (i == 57)  check("hs_x19",        12'(if_s.ctl_ch0[0]),    12'd1);
            if (i == 58)  check("hs_x20",        12'(if_s.ctl_ch0[0]),    12'd0);
            if (i == 63)  check("hs_x25",        12'(if_s.ctl_ch0[0]),    12'd0);
            if (i == 64)  check("hs_x26",        12'(if_s.ctl_ch0[0]),    12'd1);
            if (i == 218) check("pre_x28_y4",    12'(if_s.ctl_ch1),       GB ? 12'd1 : 12'd0);
            if (i == 256) check("nopre_x28_y5",  12'(if_s.ctl_ch1),       12'd0);
            if (i == 341) check("vs_y7",         12'(if_s.ctl_ch0[1]),    12'd1);
            if (i == 342) check("vs_y8",         12'(if_s.ctl_ch0[1]),    12'd0);
            if (i == 417) check("vs_y9",         12'(if_s.ctl_ch0[1]),    12'd0);
            if (i == 418) check("vs_y10",        12'(if_s.ctl_ch0[1]),    12'd1);
            if (i == 800) begin
                check("d_800_x",   if_d.x_out,                 12'd0);
                check("d_800_y",   if_d.y_out,                 12'd0);
                check("d_800_fs",  12'(if_d.frame_start),      12'd1);
                check("d_800_cov", 12'(if_d.ctrl_or_video),    12'd1);
                check("d_fs_once", 12'(dfs),                   12'd1);
            end
        end
        check("fs_first",      12'(fs1),       12'd38);
        check("fs_period",     12'(fs2 - fs1), 12'(HT * VT));
        check("video_count",   12'(vcnt),      12'(HA * VA));

        // ---------------- pix_en toggled pseudo-randomly ----------------
        for (int i = 0; i < 600; i++) begin
            pix_en = 1'($urandom_range(0, 1));
            tick();
        end

        // ---------------- reset in the middle of video ----------------
        pix_en = 1'b1;
        for (int i = 0; i < 1000 && !found; i++) begin
            tick();
            if (mx == 5 && my == 3) found = 1'b1;
        end
        check("reach_video_pt", 12'(found), 12'd1);
        rst = 1'b1;
        tick();
        check("mid_rst_x",   if_s.x_out,              12'd0);
        check("mid_rst_y",   if_s.y_out,              12'(VT - 1));
        check("mid_rst_cov", 12'(if_s.ctrl_or_video), 12'd0);
        check("mid_rst_fs",  12'(if_s.frame_start),   12'd0);
        check("mid_rst_dy",  if_d.y_out,              12'd524);
        rst = 1'b0;
        fs1 = -1;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (if_s.frame_start && fs1 < 0) fs1 = i;
        end
        check("resume_fs", 12'(fs1), 12'd38);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
